// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
// One shift-add or restoring shift-subtract step per cycle on operand
// magnitudes, followed by sign correction. The latency is fixed at WIDTH+1
// cycles from the start edge to the valid pulse, for every op and every
// operand value.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  // Magnitudes are one bit wider than the operands so that the absolute
  // value of the most-negative input never overflows.
  logic [WIDTH:0]   mag_a_reg;
  logic [WIDTH:0]   mag_b_reg;
  logic             neg_a_reg;
  logic             neg_b_reg;
  // Multiply: {acc_hi, acc_lo} is the partial product, with the multiplier
  // shifting out of acc_lo. Divide: acc_hi is the partial remainder, and
  // acc_lo shifts the dividend out while the quotient shifts in.
  logic [WIDTH:0]   acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [CW-1:0]    count_reg;

  logic             a_signed;
  logic             b_signed;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH:0]   mag_a_in;
  logic [WIDTH:0]   mag_b_in;

  logic [WIDTH+1:0] mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   result_next;
  logic               b_zero;

  // Operand signedness and magnitudes, taken from the live inputs at capture.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a_in = a_signed && a[WIDTH-1];
    neg_b_in = b_signed && b[WIDTH-1];
    mag_a_in = neg_a_in ? -{1'b1, a} : {1'b0, a};
    mag_b_in = neg_b_in ? -{1'b1, b} : {1'b0, b};
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mag_a_reg} : '0);
    div_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, mag_b_reg};
    if (op_reg[2]) begin
      if (!div_diff[WIDTH+1]) begin
        acc_hi_next = div_diff[WIDTH:0];
        acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_next = div_shift;
        acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_next = mul_sum[WIDTH+1:1];
      acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection, applied to the final step's output.
  // A zero divisor leaves the magnitude of a in the remainder, so only the
  // quotient needs an explicit override to all ones.
  always_comb begin
    b_zero   = (mag_b_reg == '0);
    prod     = {acc_hi_next[WIDTH-1:0], acc_lo_next};
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
    if (b_zero) begin
      quot_fix = '1;
    end else begin
      quot_fix = (neg_a_reg ^ neg_b_reg) ? -acc_lo_next : acc_lo_next;
    end
    rem_fix = neg_a_reg ? -acc_hi_next[WIDTH-1:0] : acc_hi_next[WIDTH-1:0];
    case (op_reg)
      OP_MUL:                       result_next = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result_next = quot_fix;
      default:                      result_next = rem_fix;
    endcase
  end

  // Control FSM: capture in IDLE, WIDTH steps in RUN, single-cycle valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      result     <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      op_reg     <= OP_MUL;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            op_reg     <= op;
            mag_a_reg  <= mag_a_in;
            mag_b_reg  <= mag_b_in;
            neg_a_reg  <= neg_a_in;
            neg_b_reg  <= neg_b_in;
            acc_hi_reg <= '0;
            acc_lo_reg <= op[2] ? mag_a_in[WIDTH-1:0] : mag_b_in[WIDTH-1:0];
            count_reg  <= CW'(WIDTH);
            busy       <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          count_reg  <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            result    <= result_next;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          valid     <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors at WIDTH=32 plus a reference
// model sweep at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = 8'd0;
  logic [7:0]  b8 = 8'd0;
  logic [7:0]  result8;
  logic        valid8;
  logic        busy8;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .valid(valid), .busy(busy)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .result(result8), .valid(valid8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // Behavioural reference for all eight ops at width w (w <= 32).
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                            input logic [31:0] a_in, input logic [31:0] b_in);
    logic [63:0] mask, ua, ub, up, out;
    longint sa, sb, sp, smin;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a_in} & mask;
    ub = {32'd0, b_in} & mask;
    sa = longint'(ua);
    if (ua[w-1]) sa = sa - (longint'(1) <<< w);
    sb = longint'(ub);
    if (ub[w-1]) sb = sb - (longint'(1) <<< w);
    smin = -(longint'(1) <<< (w - 1));
    out = 64'd0;
    case (f)
      3'b000: begin up = ua * ub; out = up; end
      3'b001: begin sp = sa * sb; out = 64'(sp >>> w); end
      3'b010: begin sp = sa * longint'(ub); out = 64'(sp >>> w); end
      3'b011: begin up = ua * ub; out = up >> w; end
      3'b100: begin
        if (ub == 64'd0) out = mask;
        else if (sa == smin && sb == -1) out = ua;
        else out = 64'(sa / sb);
      end
      3'b101: out = (ub == 64'd0) ? mask : ua / ub;
      3'b110: begin
        if (ub == 64'd0) out = ua;
        else if (sa == smin && sb == -1) out = 64'd0;
        else out = 64'(sa % sb);
      end
      default: out = (ub == 64'd0) ? ua : ua % ub;
    endcase
    out = out & mask;
    return out[31:0];
  endfunction

  // Operand picker biased towards 0, 1, -1 and the most-negative value.
  function automatic logic [31:0] pick(input int w);
    logic [63:0] m;
    logic [31:0] v;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1 << (w - 1);
      default: v = $urandom;
    endcase
    return v & m[31:0];
  endfunction

  // Issue one op on the 32-bit unit and wait (bounded) for valid.
  task automatic issue32(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] res, output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1; op = f; a = av; b = bv;
    lat = -1; res = 32'd0; busy1 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (valid) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  // Issue one op on the 8-bit unit and wait (bounded) for valid.
  task automatic issue8(input logic [2:0] f, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] res, output int lat);
    @(negedge clk);
    start8 = 1'b1; op8 = f; a8 = av; b8 = bv;
    lat = -1; res = 8'd0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (valid8) begin
        lat = c;
        res = result8;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    start8 = 1'b1; op8 = 3'd0; a8 = 8'd3; b8 = 8'd5;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (result8 !== 8'd0) begin errors++; $display("FAIL reset_result8: got %h expected 00", result8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    rst = 1'b0; start = 1'b0; start8 = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    $display("reset: busy %b valid %b result %h", busy, valid, result);
  endtask

  // Runs a directed table and checks result, latency and busy after issue.
  task automatic run_table(input string tag, input int n, input logic [2:0] fs[4],
                           input logic [31:0] as[4], input logic [31:0] bs[4], input logic [31:0] es[4]);
    logic [31:0] res;
    int lat;
    logic b1;
    for (int i = 0; i < n; i++) begin
      issue32(fs[i], as[i], bs[i], res, lat, b1);
      $display("%s[%0d]: op %0d a %h b %h -> %h latency %0d", tag, i, fs[i], as[i], bs[i], res, lat);
      checks++; if (res !== es[i]) begin errors++; $display("FAIL %s[%0d] result: got %h expected %h", tag, i, res, es[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL %s[%0d] latency: got %0d expected 33", tag, i, lat); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL %s[%0d] busy: got %b expected 1", tag, i, b1); end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  fs[4] = '{3'd0, 3'd3, 3'd2, 3'd0};
    logic [31:0] as[4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] bs[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] es[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    run_table("mul", 3, fs, as, bs, es);
    repeat (5) @(negedge clk);
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hold: got %h expected ffffffff", result); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mul_hold_valid: got %b expected 0", valid); end
  endtask

  task automatic test_div();
    logic [2:0]  fs[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] es[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    run_table("div", 4, fs, as, bs, es);
  endtask

  task automatic test_div_edge();
    logic [2:0]  fs[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    run_table("div_edge", 4, fs, as, bs, es);
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    int vcyc = -1;
    int lat = -1;
    logic [31:0] vres = 32'd0;
    logic [31:0] res = 32'd0;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (valid) begin vcnt++; vres = result; vcyc = c; end
      if (c < 33) begin
        a = a ^ 32'h0000_5A5A;
        b = b + 32'd3;
      end else begin
        a = 32'd20;
        b = 32'd4;
      end
    end
    $display("hold: valid count %0d at cycle %0d result %h", vcnt, vcyc, vres);
    checks++; if (vcnt != 1) begin errors++; $display("FAIL hold_valid_count: got %0d expected 1", vcnt); end
    checks++; if (vres !== 32'd14) begin errors++; $display("FAIL hold_result: got %h expected 0000000e", vres); end
    checks++; if (vcyc != 33) begin errors++; $display("FAIL hold_latency: got %0d expected 33", vcyc); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy %b valid %b expected 0 0", busy, valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_recapture_busy: got %b expected 1", busy); end
    start = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (valid) begin lat = c; res = result; break; end
    end
    $display("hold: second op DIVU 20/4 -> %h latency %0d", res, lat);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL b2b_result: got %h expected 00000005", res); end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_rst_abort();
    int vcnt = 0;
    int lat;
    logic b1;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", result); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", valid); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", vcnt); end
    issue32(3'd5, 32'd9, 32'd3, res, lat, b1);
    $display("abort: then DIVU 9/3 -> %h latency %0d", res, lat);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL abort_next_result: got %h expected 00000003", res); end
    checks++; if (lat != 33) begin errors++; $display("FAIL abort_next_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_random();
    int e32 = 0;
    int e8 = 0;
    int lat;
    logic b1;
    logic [2:0] f;
    logic [31:0] av, bv, exp, res;
    logic [7:0] res8, exp8;
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      av = pick(32);
      bv = pick(32);
      exp = ref_model(32, f, av, bv);
      issue32(f, av, bv, res, lat, b1);
      checks++;
      if (res !== exp || lat != 33) begin
        errors++; e32++;
        $display("FAIL rand32 op %0d a %h b %h: got %h latency %0d expected %h latency 33", f, av, bv, res, lat, exp);
      end
    end
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom_range(0, 7));
      av = pick(8);
      bv = pick(8);
      exp = ref_model(8, f, av, bv);
      exp8 = exp[7:0];
      issue8(f, av[7:0], bv[7:0], res8, lat);
      checks++;
      if (res8 !== exp8 || lat != 9) begin
        errors++; e8++;
        $display("FAIL rand8 op %0d a %h b %h: got %h latency %0d expected %h latency 9", f, av[7:0], bv[7:0], res8, lat, exp8);
      end
    end
    $display("random: 200 ops width 32 with %0d errors, 300 ops width 8 with %0d errors", e32, e8);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_edge();
    test_back_to_back();
    test_rst_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
